// File: rtl/satarx_descrambler.sv
// SATA receive-path descrambler: 16-bit LFSR reseeded per frame, one registered AXI-Stream stage.
// Optional frame-length check (DROP state, o_overflow) enabled by SATARX_DESCRAMBLER_LENCHK_EN.
module satarx_descrambler #(
  parameter logic [15:0] POLYNOMIAL   = 16'ha011,
  parameter logic [15:0] INITIAL      = 16'hffff,
  parameter logic [11:0] MAX_WORDS    = 12'd2049,
  parameter bit          OPT_LOWPOWER = 1'b1
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        i_abort,
  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TLAST,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,
  output logic        o_overflow
);

  // A zero seed would lock the LFSR at zero forever.
  if (INITIAL == 16'h0 || MAX_WORDS == 12'h0) begin : g_param_check
    $error("satarx_descrambler: INITIAL and MAX_WORDS must be nonzero");
  end

`ifdef SATARX_DESCRAMBLER_LENCHK_EN
  typedef enum logic [1:0] {IDLE, DATA, DROP} state_t;
`else
  typedef enum logic [0:0] {IDLE, DATA} state_t;
`endif

  typedef struct packed {
    logic [31:0] prn;
    logic [15:0] fill;
  } prn_step_t;

  // Runs the LFSR 32 steps; returns the PRN dword and the fill for the next dword.
  function automatic prn_step_t prn_step(input logic [15:0] fill_in);
    prn_step_t   r;
    logic [15:0] f;
    r = '0;
    // NOTE: blocking '=' is correct here; each iteration must see the fill the previous one produced.
    f = fill_in;
    for (int k = 0; k < 32; k++) begin
      r.prn[k] = f[15];
      f        = (f << 1) ^ (f[15] ? POLYNOMIAL : 16'h0);
    end
    r.fill = f;
    return r;
  endfunction

  state_t      r_state, w_state_nxt;
  logic [15:0] r_fill, w_fill_nxt;
  logic        r_m_valid, r_m_last;
  logic [31:0] r_m_data;
  prn_step_t   w_step;
  logic        w_out_ready, w_s_ready, w_in_hs, w_emit, w_drop, w_overflow;

  assign w_step      = prn_step(r_fill);
  assign w_out_ready = !r_m_valid || M_AXIS_TREADY;
  assign w_s_ready   = i_abort || w_drop || w_out_ready;
  assign w_in_hs     = S_AXIS_TVALID && w_s_ready;
  assign w_emit      = w_in_hs && !i_abort && !w_drop;

`ifdef SATARX_DESCRAMBLER_LENCHK_EN
  logic [11:0] r_count, w_count_nxt;
  logic        r_overflow;
  assign w_drop     = (r_state == DROP);
  assign o_overflow = r_overflow;
`else
  assign w_drop     = 1'b0;
  assign o_overflow = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill;
    w_overflow  = 1'b0;
`ifdef SATARX_DESCRAMBLER_LENCHK_EN
    w_count_nxt = r_count;
`endif
    if (i_abort || (w_in_hs && S_AXIS_TLAST)) begin
      w_state_nxt = IDLE;
      w_fill_nxt  = INITIAL;
`ifdef SATARX_DESCRAMBLER_LENCHK_EN
      w_count_nxt = 12'd0;
`endif
    end else if (w_in_hs && !w_drop) begin
      w_state_nxt = DATA;
      w_fill_nxt  = w_step.fill;
`ifdef SATARX_DESCRAMBLER_LENCHK_EN
      w_count_nxt = r_count + 12'd1;
      if (r_count == MAX_WORDS - 12'd1) begin
        w_state_nxt = DROP;
        w_overflow  = 1'b1;
      end
`endif
    end
  end

  // NOTE: only control and datapath registers are reset; there is no storage array in this block.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state <= IDLE;
      r_fill  <= INITIAL;
    end else begin
      r_state <= w_state_nxt;
      r_fill  <= w_fill_nxt;
    end
  end

`ifdef SATARX_DESCRAMBLER_LENCHK_EN
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_count    <= 12'd0;
      r_overflow <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_overflow <= w_overflow;
    end
  end
`endif

  // Output stage: loads only when empty or draining, so a stalled word stays put.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_m_valid <= 1'b0;
      r_m_data  <= 32'h0;
      r_m_last  <= 1'b0;
    end else if (w_out_ready) begin
      r_m_valid <= w_emit;
      if (w_emit) begin
        r_m_data <= S_AXIS_TDATA ^ w_step.prn;
        r_m_last <= S_AXIS_TLAST || w_overflow;
      end else if (OPT_LOWPOWER) begin
        r_m_data <= 32'h0;
        r_m_last <= 1'b0;
      end
    end
  end

  assign S_AXIS_TREADY = w_s_ready;
  assign M_AXIS_TVALID = r_m_valid;
  assign M_AXIS_TDATA  = r_m_data;
  assign M_AXIS_TLAST  = r_m_last;

endmodule

// File: tb/tb_satarx_descrambler.sv
// Directed bench for satarx_descrambler (MAX_WORDS=4); length-check cases follow SATARX_DESCRAMBLER_LENCHK_EN.
module tb_satarx_descrambler;

`ifdef SATARX_DESCRAMBLER_LENCHK_EN
  localparam bit LENCHK = 1'b1;
`else
  localparam bit LENCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_abort;
  logic        s_valid, s_ready, s_last;
  logic [31:0] s_data;
  logic        m_valid, m_ready, m_last;
  logic [31:0] m_data;
  logic        overflow;

  satarx_descrambler #(.MAX_WORDS(12'd4)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .i_abort(i_abort),
    .S_AXIS_TVALID(s_valid), .S_AXIS_TREADY(s_ready), .S_AXIS_TDATA(s_data), .S_AXIS_TLAST(s_last),
    .M_AXIS_TVALID(m_valid), .M_AXIS_TREADY(m_ready), .M_AXIS_TDATA(m_data), .M_AXIS_TLAST(m_last),
    .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ovf_cnt  = 0;
  logic [15:0] m_fill;
  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_prn(input logic [15:0] fill);
    logic [31:0] p;
    logic [15:0] f;
    p = '0;
    f = fill;
    for (int k = 0; k < 32; k++) begin
      p[k] = f[15];
      f    = f[15] ? ({f[14:0], 1'b0} ^ 16'ha011) : {f[14:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [15:0] model_next(input logic [15:0] fill);
    logic [15:0] f;
    f = fill;
    for (int k = 0; k < 32; k++) f = f[15] ? ({f[14:0], 1'b0} ^ 16'ha011) : {f[14:0], 1'b0};
    return f;
  endfunction

  // Output collector and overflow pulse counter, both sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) got_q.push_back({m_last, m_data});
    if (overflow) ovf_cnt++;
  end

  task automatic send_raw(input logic [31:0] s, input logic last, input logic exp_valid,
                          input logic [31:0] exp_data, input logic exp_last);
    logic hs;
    hs      = 1'b0;
    s_valid = 1'b1;
    s_data  = s;
    s_last  = last;
    for (int c = 0; c < 100 && !hs; c++) begin
      @(negedge clk);
      hs = s_ready;
      @(posedge clk);
      #1;
    end
    if (!hs) check("handshake_timeout", 64'd0, 64'd1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (exp_valid) exp_q.push_back({exp_last, exp_data});
  endtask

  task automatic send_plain(input logic [31:0] p, input logic last, input logic exp_valid,
                            input logic exp_last);
    logic [31:0] s;
    s      = p ^ model_prn(m_fill);
    m_fill = model_next(m_fill);
    send_raw(s, last, exp_valid, p, exp_last);
    if (last) m_fill = 16'hffff;
  endtask

  task automatic drain(input string tag);
    int n;
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] s3;
    logic [15:0] f;
    rst_n   = 1'b0;
    i_abort = 1'b0;
    s_valid = 1'b0;
    s_data  = 32'h0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    m_fill  = 16'hffff;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(m_valid), 64'd0);
    check("rst_tdata", 64'(m_data), 64'd0);
    check("rst_tlast", 64'(m_last), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_s_tready", 64'(s_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Loopback of a 4-word frame.
    for (int i = 1; i <= 4; i++) send_plain(32'(i), i == 4, 1'b1, i == 4);
    drain("loopback");
    check("idle_tvalid", 64'(m_valid), 64'd0);
    check("idle_lowpower_tdata", 64'(m_data), 64'd0);
    check("idle_lowpower_tlast", 64'(m_last), 64'd0);

    // Back-to-back zero frames of 3 and 2 words expose the raw PRN and the reseed.
    f = 16'hffff;
    for (int j = 0; j < 3; j++) begin
      send_raw(32'h0, j == 2, 1'b1, model_prn(f), j == 2);
      f = model_next(f);
    end
    f = 16'hffff;
    for (int j = 0; j < 2; j++) begin
      send_raw(32'h0, j == 1, 1'b1, model_prn(f), j == 1);
      f = model_next(f);
    end
    drain("b2b");

    // Five cycles of downstream backpressure mid-frame.
    send_plain(32'hdeadbeef, 1'b0, 1'b1, 1'b0);
    send_plain(32'h12345678, 1'b0, 1'b1, 1'b0);
    m_ready = 1'b0;
    s3      = 32'ha5a5a5a5 ^ model_prn(m_fill);
    m_fill  = model_next(m_fill);
    s_valid = 1'b1;
    s_data  = s3;
    repeat (5) begin
      @(negedge clk);
      check("stall_s_tready", 64'(s_ready), 64'd0);
      check("stall_tvalid", 64'(m_valid), 64'd1);
      check("stall_tdata", 64'(m_data), 64'h12345678);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    send_raw(s3, 1'b0, 1'b1, 32'ha5a5a5a5, 1'b0);
    send_plain(32'h0f0f0f0f, 1'b1, 1'b1, 1'b1);
    drain("stall");

    // 7-word frame against MAX_WORDS=4, followed by a normal 2-word frame.
    ovf_cnt = 0;
    for (int i = 1; i <= 7; i++)
      send_plain(32'h10000000 + 32'(i), i == 7, LENCHK ? (i <= 4) : 1'b1, LENCHK ? (i == 4) : (i == 7));
    send_plain(32'hcafe0001, 1'b0, 1'b1, 1'b0);
    send_plain(32'hcafe0002, 1'b1, 1'b1, 1'b1);
    drain("longframe");
    check("overflow_pulses", 64'(ovf_cnt), LENCHK ? 64'd1 : 64'd0);

    // Abort after word 2 with a coincident input word and a stalled output word.
    send_plain(32'h0000aaaa, 1'b0, 1'b1, 1'b0);
    send_plain(32'h0000bbbb, 1'b0, 1'b1, 1'b0);
    m_ready = 1'b0;
    i_abort = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'h55aa55aa;
    @(negedge clk);
    check("abort_s_tready", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;
    i_abort = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    m_fill  = 16'hffff;
    send_plain(32'h0000cccc, 1'b0, 1'b1, 1'b0);
    send_plain(32'h0000dddd, 1'b1, 1'b1, 1'b1);
    drain("abort");

    // Asynchronous reset while an output word is pending.
    m_ready = 1'b0;
    send_plain(32'h77777777, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("prerst_tvalid", 64'(m_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", 64'(m_valid), 64'd0);
    check("midrst_tdata", 64'(m_data), 64'd0);
    check("midrst_tlast", 64'(m_last), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    m_fill  = 16'hffff;
    send_plain(32'h01234567, 1'b0, 1'b1, 1'b0);
    send_plain(32'h89abcdef, 1'b1, 1'b1, 1'b1);
    drain("postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
